// File: rtl/vga_pkg.sv
// Shared VGA timing constants and screen coordinate type.
// Default geometry is 640x480 @ 60 Hz (800x525 total).
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT +
    DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT +
    DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the generator to the pixel pipeline.
// master drives it, slave observes it.
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t      h_counter;
  coord_t      v_counter;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        pixel_tick;
  logic        line_start;
  logic        frame_start;
  logic        blank_n;
  logic        sync_n;
  logic [15:0] frame_count;

  modport master (
    output h_counter, v_counter,
    output video_on, hsync, vsync,
    output pixel_tick, line_start,
    output frame_start, blank_n,
    output sync_n, frame_count
  );

  modport slave (
    input h_counter, v_counter,
    input video_on, hsync, vsync,
    input pixel_tick, line_start,
    input frame_start, blank_n,
    input sync_n, frame_count
  );

endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo counter that advances on request and flags
// the advance on which it rolls over to zero.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = DEF_H_TOTAL,
  parameter int RST_VAL = DEF_H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   advance,
  output coord_t count,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(MODULUS - 1);
  localparam coord_t INIT = coord_t'(RST_VAL);

  assign wrap = advance && (count == LAST);

  // count register, rolls to 0 after LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, syncs.
// Optional frame counter: VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX =
    DW'(CLK_DIV - 1);

  localparam coord_t H_VIS = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG =
    coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END =
    coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_BEG =
    coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END =
    coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div;
  logic          advance;
  coord_t        h, v;
  coord_t        h_nxt, v_nxt;
  logic          h_wrap, v_wrap;

  logic video_q, hsync_q, vsync_q;
  logic tick_q, line_q, frame_q;

  assign advance = enable && (div == DIV_MAX);

  // pixel clock divider, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_MAX) ? '0 : div + 1'b1;
    end
  end

  vga_wrap_counter #(
    .MODULUS (H_TOTAL),
    .RST_VAL (H_TOTAL - 1)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .count   (h),
    .wrap    (h_wrap)
  );

  vga_wrap_counter #(
    .MODULUS (V_TOTAL),
    .RST_VAL (V_TOTAL - 1)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (v),
    .wrap    (v_wrap)
  );

  // counter values after the pending advance
  always_comb begin
    h_nxt = h_wrap ? '0 : h + 1'b1;
    v_nxt = v;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v + 1'b1;
    end
  end

  // levels decoded from next-state so they align with counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_q <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      tick_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      tick_q  <= advance;
      line_q  <= h_wrap;
      frame_q <= v_wrap;
      if (advance) begin
        video_q <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync_q <= (h_nxt >= HS_BEG && h_nxt <= HS_END)
                   ? HSYNC_POL : ~HSYNC_POL;
        vsync_q <= (v_nxt >= VS_BEG && v_nxt <= VS_END)
                   ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fcnt;

  // one count per frame_start pulse, wraps at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else if (frame_q) begin
      fcnt <= fcnt + 16'd1;
    end
  end

  assign vga.frame_count = fcnt;
`else
  assign vga.frame_count = '0;
`endif

  assign vga.h_counter   = h;
  assign vga.v_counter   = v;
  assign vga.video_on    = video_q;
  assign vga.blank_n     = video_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.pixel_tick  = tick_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
  assign vga.sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// Linear pixel-index model checked against three instances.
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    int dv;
    bit hp, vp;
  } geom_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  bit   chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();

  vga_timing_gen dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .vga    (vif0)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2),
    .H_SYNC    (3), .H_BACK  (2),
    .V_VISIBLE (6), .V_FRONT (1),
    .V_SYNC    (2), .V_BACK  (1),
    .CLK_DIV   (3),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .vga    (vif1)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2),
    .H_SYNC    (3), .H_BACK  (2),
    .V_VISIBLE (6), .V_FRONT (1),
    .V_SYNC    (2), .V_BACK  (1),
    .CLK_DIV   (1),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .vga    (vif2)
  );

  function automatic geom_t geom(int i);
    geom_t g;
    if (i == 0)
      g = '{640, 16, 96, 48, 480, 10, 2, 33,
            2, 1'b0, 1'b0};
    else if (i == 1)
      g = '{8, 2, 3, 2, 6, 1, 2, 1,
            3, 1'b1, 1'b1};
    else
      g = '{8, 2, 3, 2, 6, 1, 2, 1,
            1, 1'b0, 1'b0};
    return g;
  endfunction

  function automatic int htot(int i);
    geom_t g = geom(i);
    return g.hv + g.hf + g.hs + g.hb;
  endfunction

  function automatic int frm(int i);
    geom_t g = geom(i);
    return htot(i) * (g.vv + g.vf + g.vs + g.vb);
  endfunction

  // model: divider phase and linear pixel index in the frame
  int m_div [3];
  int m_pos [3];
  bit m_tick [3];
  int m_fc [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_div[i]  <= 0;
        m_pos[i]  <= frm(i) - 1;
        m_tick[i] <= 1'b0;
        m_fc[i]   <= 0;
      end else begin
        if (m_tick[i] && m_pos[i] == 0)
          m_fc[i] <= (m_fc[i] + 1) % 65536;
        if (enable && m_div[i] == geom(i).dv - 1) begin
          m_div[i]  <= 0;
          m_pos[i]  <= (m_pos[i] + 1) % frm(i);
          m_tick[i] <= 1'b1;
        end else begin
          if (enable) m_div[i] <= m_div[i] + 1;
          m_tick[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  task automatic check_inst(
    int i, int h, int v, bit von, bit hs, bit vs,
    bit tk, bit ls, bit fs, bit bn, bit sn, int fc
  );
    geom_t g = geom(i);
    int ht = htot(i);
    int eh = m_pos[i] % ht;
    int ev = m_pos[i] / ht;
    bit evid = eh < g.hv && ev < g.vv;
    bit ehs = (eh >= g.hv + g.hf &&
               eh < g.hv + g.hf + g.hs) ? g.hp : !g.hp;
    bit evs = (ev >= g.vv + g.vf &&
               ev < g.vv + g.vf + g.vs) ? g.vp : !g.vp;
    bit etk = m_tick[i];
    int efc = 0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    efc = m_fc[i];
`endif
    chk($sformatf("u%0d_h", i), h, eh);
    chk($sformatf("u%0d_v", i), v, ev);
    chk($sformatf("u%0d_video_on", i), int'(von), int'(evid));
    chk($sformatf("u%0d_blank_n", i), int'(bn), int'(evid));
    chk($sformatf("u%0d_hsync", i), int'(hs), int'(ehs));
    chk($sformatf("u%0d_vsync", i), int'(vs), int'(evs));
    chk($sformatf("u%0d_tick", i), int'(tk), int'(etk));
    chk($sformatf("u%0d_line_start", i), int'(ls),
        int'(etk && eh == 0));
    chk($sformatf("u%0d_frame_start", i), int'(fs),
        int'(etk && m_pos[i] == 0));
    chk($sformatf("u%0d_sync_n", i), int'(sn), 0);
    chk($sformatf("u%0d_frame_count", i), fc, efc);
  endtask

  // per-line (u0) and per-frame (u1,u2) tick statistics
  int c_tick [3];
  int c_ls [3];
  int c_vid [3];
  int c_hs [3];
  int c_vs [3];
  int c_lv [3];
  bit seen [3];

  task automatic acc(
    int i, int h, int v, bit tk, bit ls, bit fs,
    bit von, bit hsa, bit vsa
  );
    bit bnd = (i == 0) ? ls : fs;
    if (!rst_n) begin
      seen[i] = 1'b0;
      return;
    end
    if (tk && bnd) begin
      if (seen[i] && i == 0) begin
        chk("u0_line_ticks", c_tick[i], 800);
        chk("u0_line_hsync_ticks", c_hs[i], 96);
        if (c_lv[i] < 480)
          chk("u0_line_video_ticks", c_vid[i], 640);
      end else if (seen[i]) begin
        chk($sformatf("u%0d_frame_ticks", i), c_tick[i], 150);
        chk($sformatf("u%0d_frame_lines", i), c_ls[i], 10);
        chk($sformatf("u%0d_frame_video", i), c_vid[i], 48);
        chk($sformatf("u%0d_frame_hsync", i), c_hs[i], 30);
        chk($sformatf("u%0d_frame_vsync", i), c_vs[i], 30);
      end
      seen[i]  = 1'b1;
      c_tick[i] = 0;
      c_ls[i]  = 0;
      c_vid[i] = 0;
      c_hs[i]  = 0;
      c_vs[i]  = 0;
      c_lv[i]  = v;
    end
    if (tk) begin
      c_tick[i]++;
      c_ls[i]  += int'(ls);
      c_vid[i] += int'(von);
      c_hs[i]  += int'(hsa);
      c_vs[i]  += int'(vsa);
    end
    if (i == 0 && tk && v < 480) begin
      if (h == 639) chk("u0_vid_h639", int'(von), 1);
      if (h == 640) chk("u0_vid_h640", int'(von), 0);
      if (h == 655) chk("u0_hs_h655", int'(hsa), 0);
      if (h == 656) chk("u0_hs_h656", int'(hsa), 1);
      if (h == 751) chk("u0_hs_h751", int'(hsa), 1);
      if (h == 752) chk("u0_hs_h752", int'(hsa), 0);
    end
  endtask

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, vif0.h_counter, vif0.v_counter,
        vif0.video_on, vif0.hsync, vif0.vsync,
        vif0.pixel_tick, vif0.line_start,
        vif0.frame_start, vif0.blank_n, vif0.sync_n,
        vif0.frame_count);
      check_inst(1, vif1.h_counter, vif1.v_counter,
        vif1.video_on, vif1.hsync, vif1.vsync,
        vif1.pixel_tick, vif1.line_start,
        vif1.frame_start, vif1.blank_n, vif1.sync_n,
        vif1.frame_count);
      check_inst(2, vif2.h_counter, vif2.v_counter,
        vif2.video_on, vif2.hsync, vif2.vsync,
        vif2.pixel_tick, vif2.line_start,
        vif2.frame_start, vif2.blank_n, vif2.sync_n,
        vif2.frame_count);
      acc(0, vif0.h_counter, vif0.v_counter,
        vif0.pixel_tick, vif0.line_start,
        vif0.frame_start, vif0.video_on,
        vif0.hsync == 1'b0, vif0.vsync == 1'b0);
      acc(1, vif1.h_counter, vif1.v_counter,
        vif1.pixel_tick, vif1.line_start,
        vif1.frame_start, vif1.video_on,
        vif1.hsync == 1'b1, vif1.vsync == 1'b1);
      acc(2, vif2.h_counter, vif2.v_counter,
        vif2.pixel_tick, vif2.line_start,
        vif2.frame_start, vif2.video_on,
        vif2.hsync == 1'b0, vif2.vsync == 1'b0);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sh, sv;
    bit found;

    #2 rst_n = 1'b0;
    enable = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_h", vif0.h_counter, 799);
    chk("rst_v", vif0.v_counter, 524);
    chk("rst_video_on", vif0.video_on, 0);
    chk("rst_hsync", vif0.hsync, 1);
    chk("rst_vsync", vif0.vsync, 1);
    chk("rst_tick", vif0.pixel_tick, 0);
    chk("rst_u1_hsync", vif1.hsync, 0);
    chk("rst_frame_count", vif0.frame_count, 0);

    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_clk1_tick", vif0.pixel_tick, 0);
    @(negedge clk);
    chk("first_clk2_tick", vif0.pixel_tick, 1);
    chk("first_h", vif0.h_counter, 0);
    chk("first_v", vif0.v_counter, 0);
    chk("first_frame_start", vif0.frame_start, 1);
    chk("first_line_start", vif0.line_start, 1);
    chk("first_video_on", vif0.video_on, 1);

    repeat (4000) @(negedge clk);

    repeat (6000) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) != 0);
    end

    enable = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (vif0.pixel_tick && vif0.h_counter == 300)
        found = 1'b1;
    end
    chk("wait_h300", int'(found), 1);
    if (found) begin
      enable = 1'b0;
      sh = vif0.h_counter;
      sv = vif0.v_counter;
      repeat (50) begin
        @(negedge clk);
        chk("hold_tick", vif0.pixel_tick, 0);
        chk("hold_line", vif0.line_start, 0);
        chk("hold_frame", vif0.frame_start, 0);
        chk("hold_h", vif0.h_counter, sh);
        chk("hold_v", vif0.v_counter, sv);
        chk("hold_video", vif0.video_on, 1);
      end
      enable = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
        @(negedge clk);
        if (vif0.pixel_tick) found = 1'b1;
      end
      chk("resume_tick", int'(found), 1);
      chk("resume_h", vif0.h_counter, 301);
    end

    repeat (12000) @(negedge clk);

    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (vif0.pixel_tick && vif0.h_counter == 700)
        found = 1'b1;
    end
    chk("wait_h700", int'(found), 1);
    @(posedge clk);
    #1;
    chk("pre_rst_h", vif0.h_counter, 700);
    #1 rst_n = 1'b0;
    #1;
    chk("async_h", vif0.h_counter, 799);
    chk("async_v", vif0.v_counter, 524);
    chk("async_video", vif0.video_on, 0);
    chk("async_blank_n", vif0.blank_n, 0);
    chk("async_hsync", vif0.hsync, 1);
    chk("async_vsync", vif0.vsync, 1);
    chk("async_tick", vif0.pixel_tick, 0);
    chk("async_line", vif0.line_start, 0);
    chk("async_frame", vif0.frame_start, 0);
    chk("async_fc", vif0.frame_count, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2000) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
